// File: rtl/ddr_sched_pkg.sv
// rtl/ddr_sched_pkg.sv - shared types and constants for the DDR pair scheduler
// Contents:
//   state_e         scheduler state (IDLE, RUN, DRAIN)
//   SRC_A / SRC_B   tag source encodings
//   sample_width()  sample width derived from the BW offset parameter
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int SAMPLE_W_OFFSET = 15;

  function automatic int sample_width(input int bw);
    return bw + SAMPLE_W_OFFSET;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - per-requester FIFO with 1-word push and 0/1/2-word pop
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears pointers/count only)
//   push        write push_data this cycle
//   push_data   word to write
//   pop_cnt     number of words removed this cycle (0, 1 or 2)
//   head0/head1 oldest and second-oldest words
//   count       words currently held (0..DEPTH)
module pair_fifo
  import ddr_sched_pkg::*;
#(
  parameter int W     = sample_width(6),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic [1:0]               pop_cnt,
  output logic [W-1:0]             head0,
  output logic [W-1:0]             head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits, so the additions wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; an empty count makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign head0 = mem[rd_ptr_q];
  assign head1 = mem[rd_ptr_q + PW'(1)];
  assign count = count_q;

endmodule

// File: rtl/ddr_pair_scheduler.sv
// rtl/ddr_pair_scheduler.sv - feeds the two DDR mux slots from requesters A and B
// Ports:
//   CLK, RES          clock, asynchronous active-high reset
//   EN                run enable; dropping it while running starts a drain
//   A_DATA/A_VALID    requester A word and offer; A_READY accepts it
//   B_DATA/B_VALID    requester B word and offer; B_READY accepts it
//   OUT1/OUT2         mux IN1 (CLK high slot) / IN2 (CLK low slot)
//   TAG_VLD[1:0]      per-slot data-valid, bit0=slot1, bit1=slot2
//   TAG_SRC[1:0]      per-slot source (0=A, 1=B), 0 on idle slots
//   BUSY              high in RUN or DRAIN
module ddr_pair_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int              BW        = 6,
  parameter int              DEPTH     = 4,
  parameter logic [BW+14:0]  IDLE_WORD = '0
) (
  input  logic           CLK,
  input  logic           RES,
  input  logic           EN,
  input  logic [BW+14:0] A_DATA,
  input  logic           A_VALID,
  output logic           A_READY,
  input  logic [BW+14:0] B_DATA,
  input  logic           B_VALID,
  output logic           B_READY,
  output logic [BW+14:0] OUT1,
  output logic [BW+14:0] OUT2,
  output logic [1:0]     TAG_VLD,
  output logic [1:0]     TAG_SRC,
  output logic           BUSY
);

  localparam int SW = sample_width(BW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SW-1:0] a_head0, a_head1, b_head0, b_head1;
  logic [CW-1:0] a_count, b_count;
  logic [CW-1:0] a_count_nxt, b_count_nxt;
  logic [1:0]    a_pop, b_pop;
  logic          a_push, b_push;
  logic          a_has, b_has;

  state_e        state_q, state_d;
  logic          pri_q, pri_d;
  logic [SW-1:0] out1_q, out1_d, out2_q, out2_d;
  logic [1:0]    tag_vld_q, tag_vld_d, tag_src_q, tag_src_d;
  logic          a_ready_q, a_ready_d, b_ready_q, b_ready_d;

  assign a_push = A_VALID && a_ready_q;
  assign b_push = B_VALID && b_ready_q;
  // Pop decisions see only words present before this cycle's push.
  assign a_has  = (a_count != '0);
  assign b_has  = (b_count != '0);

  pair_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (CLK),
    .rst       (RES),
    .push      (a_push),
    .push_data (A_DATA),
    .pop_cnt   (a_pop),
    .head0     (a_head0),
    .head1     (a_head1),
    .count     (a_count)
  );

  pair_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (CLK),
    .rst       (RES),
    .push      (b_push),
    .push_data (B_DATA),
    .pop_cnt   (b_pop),
    .head0     (b_head0),
    .head1     (b_head1),
    .count     (b_count)
  );

  // Slot selection: both non-empty -> one word each, PRI source first, then
  // PRI flips; a lone non-empty FIFO fills as many slots as it can.
  always_comb begin
    a_pop     = 2'd0;
    b_pop     = 2'd0;
    pri_d     = pri_q;
    out1_d    = IDLE_WORD;
    out2_d    = IDLE_WORD;
    tag_vld_d = 2'b00;
    tag_src_d = 2'b00;
    if (state_q != IDLE) begin
      if (a_has && b_has) begin
        a_pop     = 2'd1;
        b_pop     = 2'd1;
        tag_vld_d = 2'b11;
        pri_d     = ~pri_q;
        if (pri_q == SRC_A) begin
          out1_d    = a_head0;
          out2_d    = b_head0;
          tag_src_d = {SRC_B, SRC_A};
        end else begin
          out1_d    = b_head0;
          out2_d    = a_head0;
          tag_src_d = {SRC_A, SRC_B};
        end
      end else if (a_has) begin
        out1_d = a_head0;
        if (a_count >= CW'(2)) begin
          out2_d    = a_head1;
          a_pop     = 2'd2;
          tag_vld_d = 2'b11;
        end else begin
          a_pop     = 2'd1;
          tag_vld_d = 2'b01;
        end
        tag_src_d = {SRC_A, SRC_A};
      end else if (b_has) begin
        out1_d = b_head0;
        if (b_count >= CW'(2)) begin
          out2_d    = b_head1;
          b_pop     = 2'd2;
          tag_vld_d = 2'b11;
          tag_src_d = {SRC_B, SRC_B};
        end else begin
          b_pop     = 2'd1;
          tag_vld_d = 2'b01;
          tag_src_d = {SRC_A, SRC_B};
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (EN) state_d = RUN;
      RUN:     if (!EN) state_d = DRAIN;
      DRAIN: begin
        if (EN) begin
          state_d = RUN;
        end else if (!a_has && !b_has) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // READY is registered from next-cycle occupancy, so a full FIFO never
  // sees another push and count stays within DEPTH.
  always_comb begin
    a_count_nxt = a_count + CW'(a_push) - CW'(a_pop);
    b_count_nxt = b_count + CW'(b_push) - CW'(b_pop);
    a_ready_d   = (a_count_nxt < CW'(DEPTH)) && (state_d != DRAIN);
    b_ready_d   = (b_count_nxt < CW'(DEPTH)) && (state_d != DRAIN);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= IDLE;
      pri_q     <= SRC_A;
      out1_q    <= IDLE_WORD;
      out2_q    <= IDLE_WORD;
      tag_vld_q <= 2'b00;
      tag_src_q <= 2'b00;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      tag_vld_q <= tag_vld_d;
      tag_src_q <= tag_src_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
    end
  end

  assign OUT1    = out1_q;
  assign OUT2    = out2_q;
  assign TAG_VLD = tag_vld_q;
  assign TAG_SRC = tag_src_q;
  assign A_READY = a_ready_q;
  assign B_READY = b_ready_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_pair_scheduler.sv
// tb/tb_ddr_pair_scheduler.sv - directed self-checking bench for ddr_pair_scheduler
module tb_ddr_pair_scheduler;

  typedef logic [20:0] smp_t;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        EN = 1'b0;
  smp_t        A_DATA = '0;
  logic        A_VALID = 1'b0;
  logic        A_READY;
  smp_t        B_DATA = '0;
  logic        B_VALID = 1'b0;
  logic        B_READY;
  smp_t        OUT1, OUT2;
  logic [1:0]  TAG_VLD, TAG_SRC;
  logic        BUSY;

  logic [45:0] obs;
  logic [45:0] exp_v;
  logic [2:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  assign obs = {OUT1, OUT2, TAG_VLD, TAG_SRC};
  assign ctl = {BUSY, A_READY, B_READY};

  ddr_pair_scheduler dut (
    .CLK     (CLK),
    .RES     (RES),
    .EN      (EN),
    .A_DATA  (A_DATA),
    .A_VALID (A_VALID),
    .A_READY (A_READY),
    .B_DATA  (B_DATA),
    .B_VALID (B_VALID),
    .B_READY (B_READY),
    .OUT1    (OUT1),
    .OUT2    (OUT2),
    .TAG_VLD (TAG_VLD),
    .TAG_SRC (TAG_SRC),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    EN = 1'b0;
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    step();
    step();
    RES = 1'b0;
  endtask

  // Offers words on A and/or B, waits for the needed READYs, then takes one edge.
  task automatic push_pair(input logic va, input smp_t a, input logic vb, input smp_t b);
    int n;
    A_VALID = va;
    A_DATA  = a;
    B_VALID = vb;
    B_DATA  = b;
    n = 0;
    while (((va && !A_READY) || (vb && !B_READY)) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready got %b%b required 11", A_READY, B_READY);
    end
    step();
    A_VALID = 1'b0;
    B_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RES = 1'b1;
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", obs, 46'd0);
    end
    checks++;
    if (ctl !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 000", ctl);
    end
    RES = 1'b0;
    step();
    checks++;
    if (ctl !== 3'b011) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 011", ctl);
    end
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int i = 10; i < 14; i++) push_pair(1'b1, smp_t'(i), 1'b0, '0);
    EN = 1'b1;
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t1_start_idle: got %h required %h", obs, 46'd0);
    end
    step();
    exp_v = {smp_t'(10), smp_t'(11), 2'b11, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t1_pair0: got %h required %h", obs, exp_v);
    end
    step();
    exp_v = {smp_t'(12), smp_t'(13), 2'b11, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t1_pair1: got %h required %h", obs, exp_v);
    end
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t1_empty: got %h required %h", obs, 46'd0);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    push_pair(1'b1, smp_t'(1), 1'b1, smp_t'(-5));
    push_pair(1'b1, smp_t'(2), 1'b1, smp_t'(-6));
    EN = 1'b1;
    step();
    step();
    exp_v = {smp_t'(1), smp_t'(-5), 2'b11, 2'b10};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t2_cycle1: got %h required %h", obs, exp_v);
    end
    step();
    exp_v = {smp_t'(-6), smp_t'(2), 2'b11, 2'b01};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t2_cycle2: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_single_word();
    push_pair(1'b1, smp_t'(7), 1'b0, '0);
    step();
    exp_v = {smp_t'(7), smp_t'(0), 2'b01, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t3_single: got %h required %h", obs, exp_v);
    end
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t3_after: got %h required %h", obs, 46'd0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i < 5; i++) push_pair(1'b1, smp_t'(i), 1'b0, '0);
    checks++;
    if (A_READY !== 1'b0) begin
      errors++;
      $display("FAIL t4_full_ready: got %b required 0", A_READY);
    end
    A_VALID = 1'b1;
    A_DATA  = smp_t'(5);
    step();
    step();
    checks++;
    if (A_READY !== 1'b0) begin
      errors++;
      $display("FAIL t4_still_full: got %b required 0", A_READY);
    end
    A_VALID = 1'b0;
    EN = 1'b1;
    step();
    step();
    exp_v = {smp_t'(1), smp_t'(2), 2'b11, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t4_pair0: got %h required %h", obs, exp_v);
    end
    step();
    exp_v = {smp_t'(3), smp_t'(4), 2'b11, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t4_pair1: got %h required %h", obs, exp_v);
    end
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t4_no_fifth: got %h required %h", obs, 46'd0);
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 30; i < 33; i++) push_pair(1'b1, smp_t'(i), 1'b0, '0);
    EN = 1'b1;
    step();
    checks++;
    if (ctl !== 3'b111) begin
      errors++;
      $display("FAIL t5_run_ctl: got %b required 111", ctl);
    end
    EN = 1'b0;
    step();
    checks++;
    if (ctl !== 3'b100) begin
      errors++;
      $display("FAIL t5_drain1_ctl: got %b required 100", ctl);
    end
    exp_v = {smp_t'(30), smp_t'(31), 2'b11, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t5_drain1_out: got %h required %h", obs, exp_v);
    end
    step();
    checks++;
    if (ctl !== 3'b100) begin
      errors++;
      $display("FAIL t5_drain2_ctl: got %b required 100", ctl);
    end
    exp_v = {smp_t'(32), smp_t'(0), 2'b01, 2'b00};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t5_drain2_out: got %h required %h", obs, exp_v);
    end
    step();
    checks++;
    if (ctl !== 3'b011) begin
      errors++;
      $display("FAIL t5_idle_ctl: got %b required 011", ctl);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push_pair(1'b1, smp_t'(40), 1'b1, smp_t'(50));
    push_pair(1'b1, smp_t'(41), 1'b0, '0);
    EN = 1'b1;
    step();
    step();
    exp_v = {smp_t'(40), smp_t'(50), 2'b11, 2'b10};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t6_before: got %h required %h", obs, exp_v);
    end
    #2;
    RES = 1'b1;
    #1;
    checks++;
    if ({obs, ctl} !== 49'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got %h required %h", {obs, ctl}, 49'd0);
    end
    step();
    RES = 1'b0;
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t6_post1: got %h required %h", obs, 46'd0);
    end
    step();
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL t6_no_stale: got %h required %h", obs, 46'd0);
    end
    push_pair(1'b1, smp_t'(60), 1'b1, smp_t'(70));
    step();
    exp_v = {smp_t'(60), smp_t'(70), 2'b11, 2'b10};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL t6_pri_reset: got %h required %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_interleave();
    test_single_word();
    test_backpressure();
    test_drain();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
